instr_encoder_loader: RTL and testbench

//  Inverse of the instruction decoder. Accepts assembled fields (opcode, DR, SA, SB, IMM) over a valid/ready stream.

---
 rtl/instr_encoder_loader_pkg.sv | 64 ++++++
 rtl/instr_encoder_loader_packer.sv | 46 ++++
 rtl/instr_encoder_loader.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the instruction encoder/loader: opcode values (same as the decoder),
// error codes, FSM states and the opcode-to-format classification.
package instr_encoder_loader_pkg;

  localparam logic [6:0] OP_NOP = 7'h00;
  localparam logic [6:0] OP_ADD = 7'h02;
  localparam logic [6:0] OP_SUB = 7'h05;
  localparam logic [6:0] OP_SLT = 7'h65;
  localparam logic [6:0] OP_AND = 7'h08;
  localparam logic [6:0] OP_OR  = 7'h09;
  localparam logic [6:0] OP_XOR = 7'h0A;
  localparam logic [6:0] OP_ST  = 7'h20;
  localparam logic [6:0] OP_LOD = 7'h21;
  localparam logic [6:0] OP_NOT = 7'h0B;
  localparam logic [6:0] OP_MOV = 7'h40;
  localparam logic [6:0] OP_LSL = 7'h0C;
  localparam logic [6:0] OP_LSR = 7'h0D;
  localparam logic [6:0] OP_JMR = 7'h61;
  localparam logic [6:0] OP_ADI = 7'h42;
  localparam logic [6:0] OP_SBI = 7'h45;
  localparam logic [6:0] OP_ANI = 7'h48;
  localparam logic [6:0] OP_ORI = 7'h49;
  localparam logic [6:0] OP_XRI = 7'h4A;
  localparam logic [6:0] OP_AIU = 7'h52;
  localparam logic [6:0] OP_SIU = 7'h55;
  localparam logic [6:0] OP_BZ  = 7'h60;
  localparam logic [6:0] OP_BNZ = 7'h69;
  localparam logic [6:0] OP_JMP = 7'h44;
  localparam logic [6:0] OP_JML = 7'h30;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } enc_state_e;

  typedef enum logic [2:0] {
    CLS_NOP        = 3'd0,
    CLS_R          = 3'd1,
    CLS_I_SIGNED   = 3'd2,
    CLS_I_UNSIGNED = 3'd3,
    CLS_ILLEGAL    = 3'd4
  } op_class_e;

  function automatic op_class_e op_class(input logic [6:0] op);
    op_class_e cls;
    case (op)
      OP_NOP: cls = CLS_NOP;
      OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_OR, OP_XOR, OP_ST,
      OP_LOD, OP_NOT, OP_MOV, OP_LSL, OP_LSR, OP_JMR: cls = CLS_R;
      OP_ADI, OP_SBI, OP_BZ, OP_BNZ, OP_JMP, OP_JML: cls = CLS_I_SIGNED;
      OP_ANI, OP_ORI, OP_XRI, OP_AIU, OP_SIU: cls = CLS_I_UNSIGNED;
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_packer.sv
// Combinational field packer: classifies the opcode, checks the immediate range for its
// class and builds the 32-bit instruction word.
module instr_field_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [6:0]  op_i,
  input  logic [4:0]  dr_i,
  input  logic [4:0]  sa_i,
  input  logic [4:0]  sb_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        range_err_o
);

  op_class_e cls_s;

  assign cls_s = op_class(op_i);

  // Signed immediates fit 15 bits when bits 15 and 14 agree; unsigned ones need bit 15 clear.
  always_comb begin
    word_o      = 32'h0000_0000;
    illegal_o   = 1'b0;
    range_err_o = 1'b0;
    case (cls_s)
      CLS_NOP: begin
        word_o = 32'h0000_0000;
      end
      CLS_R: begin
        word_o = {op_i, dr_i, sa_i, sb_i, 10'd0};
      end
      CLS_I_SIGNED: begin
        word_o      = {op_i, dr_i, sa_i, imm_i[14:0]};
        range_err_o = (imm_i[15] != imm_i[14]);
      end
      CLS_I_UNSIGNED: begin
        word_o      = {op_i, dr_i, sa_i, imm_i[14:0]};
        range_err_o = imm_i[15];
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes field bundles from a valid/ready stream and writes them to
// sequential instruction-memory addresses. Define ENC_CHECKSUM_EN to add the XOR checksum port.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [6:0]        in_op_i,
  input  logic [4:0]        in_dr_i,
  input  logic [4:0]        in_sa_i,
  input  logic [4:0]        in_sb_i,
  input  logic [15:0]       in_imm_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
`ifdef ENC_CHECKSUM_EN
  output logic [31:0]       checksum_o,
`endif
  output logic [ADDR_W:0]   word_count_o
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              full_q, full_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        code_q, code_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]       cks_q, cks_d;
`endif

  logic [31:0] word_s;
  logic        illegal_s;
  logic        range_err_s;

  instr_field_packer u_packer (
    .op_i        (in_op_i),
    .dr_i        (in_dr_i),
    .sa_i        (in_sa_i),
    .sb_i        (in_sb_i),
    .imm_i       (in_imm_i),
    .word_o      (word_s),
    .illegal_o   (illegal_s),
    .range_err_o (range_err_s)
  );

  // full_q marks that the last address has been written, so the pointer never wraps.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    count_d = count_q;
    code_d  = code_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ENC_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d = ST_RUN;
          ptr_d   = BASE_ADDR;
          full_d  = 1'b0;
          count_d = {(ADDR_W+1){1'b0}};
          code_d  = ERR_NONE;
`ifdef ENC_CHECKSUM_EN
          cks_d   = 32'h0000_0000;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (!in_valid_i) begin
          state_d = ST_RUN;
        end else if (illegal_s) begin
          state_d = ST_ERROR;
          code_d  = ERR_ILLEGAL;
        end else if (range_err_s) begin
          state_d = ST_ERROR;
          code_d  = ERR_RANGE;
        end else if (full_q) begin
          state_d = ST_ERROR;
          code_d  = ERR_OVERFLOW;
        end else begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = word_s;
          count_d = count_q + COUNT_ONE;
`ifdef ENC_CHECKSUM_EN
          cks_d   = cks_q ^ word_s;
`endif
          if (ptr_q == ADDR_MAX) begin
            full_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_ONE;
          end
          if (in_last_i) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts a session and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= {ADDR_W{1'b0}};
      full_q  <= 1'b0;
      count_q <= {(ADDR_W+1){1'b0}};
      code_q  <= ERR_NONE;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= 32'h0000_0000;
`ifdef ENC_CHECKSUM_EN
      cks_q   <= 32'h0000_0000;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
      count_q <= count_d;
      code_q  <= code_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef ENC_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  assign in_ready_o   = (state_q == ST_RUN);
  assign busy_o       = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = (state_q == ST_ERROR);
  assign err_code_o   = code_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign word_count_o = count_q;
`ifdef ENC_CHECKSUM_EN
  assign checksum_o   = cks_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader (ADDR_W=2 so overflow is reachable), checked
// against a behavioural model built from opcode tables and integer range arithmetic.
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_last = 1'b0;
  logic [6:0]    in_op = 7'h00;
  logic [4:0]    in_dr = 5'd0, in_sa = 5'd0, in_sb = 5'd0;
  logic [15:0]   in_imm = 16'h0000;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(2'd0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_last_i    (in_last),
    .in_op_i      (in_op),
    .in_dr_i      (in_dr),
    .in_sa_i      (in_sa),
    .in_sb_i      (in_sb),
    .in_imm_i     (in_imm),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .err_code_o   (err_code),
`ifdef ENC_CHECKSUM_EN
    .checksum_o   (checksum),
`endif
    .word_count_o (word_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Opcode tables, independent copies of the decoder's values.
  logic [6:0] r_ops [13] = '{7'h02, 7'h05, 7'h65, 7'h08, 7'h09, 7'h0A, 7'h20,
                             7'h21, 7'h0B, 7'h40, 7'h0C, 7'h0D, 7'h61};
  logic [6:0] s_ops [6]  = '{7'h42, 7'h45, 7'h60, 7'h69, 7'h44, 7'h30};
  logic [6:0] u_ops [5]  = '{7'h48, 7'h49, 7'h4A, 7'h52, 7'h55};

  // 0 NOP, 1 register form, 2 signed immediate, 3 unsigned immediate, -1 unassigned
  function automatic int op_kind(input logic [6:0] op);
    if (op == 7'h00) return 0;
    foreach (r_ops[i]) if (r_ops[i] == op) return 1;
    foreach (s_ops[i]) if (s_ops[i] == op) return 2;
    foreach (u_ops[i]) if (u_ops[i] == op) return 3;
    return -1;
  endfunction

  function automatic logic [6:0] pick_legal();
    int k;
    k = $urandom_range(0, 24);
    if (k == 24) return 7'h00;
    if (k < 13) return r_ops[k];
    if (k < 19) return s_ops[k-13];
    return u_ops[k-19];
  endfunction

  // Model state: 0 idle, 1 run, 2 done, 3 error
  int          m_state = 0;
  int          m_addr  = 0;
  int          m_count = 0;
  int          m_code  = 0;
  logic [31:0] m_cks   = 32'h0;
  bit          exp_we;
  int          exp_addr;
  logic [31:0] exp_data;

  task automatic model_step(input bit st, input bit v, input bit l, input logic [6:0] op,
                            input logic [4:0] dr, input logic [4:0] sa, input logic [4:0] sb,
                            input logic [15:0] imm);
    int kind, s;
    logic [31:0] w;
    exp_we = 1'b0;
    if (m_state != 1 && st) begin
      m_state = 1; m_addr = 0; m_count = 0; m_code = 0; m_cks = 32'h0;
    end else if (m_state == 1 && v) begin
      kind = op_kind(op);
      s = $signed(imm);
      w = ({25'd0, op} << 25) + ({27'd0, dr} << 20) + ({27'd0, sa} << 15);
      if (kind == 1) w = w + ({27'd0, sb} << 10);
      if (kind >= 2) w = w + (s & 32'h7FFF);
      if (kind == 0) w = 32'h0;
      if (kind < 0) begin
        m_state = 3; m_code = 1;
      end else if ((kind == 2 && (s < -16384 || s > 16383)) ||
                   (kind == 3 && (s < 0 || s > 32767))) begin
        m_state = 3; m_code = 2;
      end else if (m_addr > (1 << AW) - 1) begin
        m_state = 3; m_code = 3;
      end else begin
        exp_we = 1'b1; exp_addr = m_addr; exp_data = w;
        m_addr++; m_count++; m_cks = m_cks ^ w;
        if (l) m_state = 2;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".we"}, 64'(imem_we), 64'(exp_we));
    if (exp_we) begin
      check_eq({tag, ".addr"}, 64'(imem_addr), 64'(exp_addr));
      check_eq({tag, ".wdata"}, 64'(imem_wdata), 64'(exp_data));
    end
    check_eq({tag, ".ready"}, 64'(in_ready), 64'(m_state == 1));
    check_eq({tag, ".busy"}, 64'(busy), 64'(m_state == 1));
    check_eq({tag, ".done"}, 64'(done), 64'(m_state == 2));
    check_eq({tag, ".err"}, 64'(err), 64'(m_state == 3));
    check_eq({tag, ".code"}, 64'(err_code), 64'(m_code));
    check_eq({tag, ".count"}, 64'(word_count), 64'(m_count));
`ifdef ENC_CHECKSUM_EN
    check_eq({tag, ".cks"}, 64'(checksum), 64'(m_cks));
`endif
  endtask

  task automatic step(input string tag, input bit st, input bit v, input bit l,
                      input logic [6:0] op, input logic [4:0] dr, input logic [4:0] sa,
                      input logic [4:0] sb, input logic [15:0] imm);
    @(negedge clk);
    start = st; in_valid = v; in_last = l; in_op = op;
    in_dr = dr; in_sa = sa; in_sb = sb; in_imm = imm;
    model_step(st, v, l, op, dr, sa, sb, imm);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".we"}, 64'(imem_we), 64'd0);
    check_eq({tag, ".addr"}, 64'(imem_addr), 64'd0);
    check_eq({tag, ".wdata"}, 64'(imem_wdata), 64'd0);
    check_eq({tag, ".flags"}, 64'({in_ready, busy, done, err}), 64'd0);
    check_eq({tag, ".code"}, 64'(err_code), 64'd0);
    check_eq({tag, ".count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    logic [15:0] imm_r;
    logic [6:0]  op_r;
    int          sel;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADD with LAST: single word at BASE_ADDR, then DONE
    step("add_start", 1'b1, 1'b0, 1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    step("add", 1'b0, 1'b1, 1'b1, 7'h02, 5'd3, 5'd1, 5'd2, 16'h0);
    check_eq("add.word", 64'(imem_wdata), 64'({7'h02, 5'd3, 5'd1, 5'd2, 10'd0}));

    // ADI -1 packs to 15'h7FFF, ANI -1 is out of range
    step("adi_start", 1'b1, 1'b0, 1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    step("adi", 1'b0, 1'b1, 1'b0, 7'h42, 5'd1, 5'd0, 5'd0, 16'hFFFF);
    check_eq("adi.word", 64'(imem_wdata), 64'({7'h42, 5'd1, 5'd0, 15'h7FFF}));
    step("ani", 1'b0, 1'b1, 1'b0, 7'h48, 5'd1, 5'd0, 5'd0, 16'hFFFF);
    check_eq("ani.code", 64'(err_code), 64'(2'b10));

    // Unassigned opcode, then a new session restarts from BASE_ADDR
    step("ill_start", 1'b1, 1'b0, 1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    step("ill", 1'b0, 1'b1, 1'b0, 7'h7F, 5'd1, 5'd1, 5'd1, 16'h0);
    check_eq("ill.code", 64'(err_code), 64'(2'b01));
    step("ill_idle", 1'b0, 1'b1, 1'b0, 7'h02, 5'd1, 5'd1, 5'd1, 16'h0);
    step("re_start", 1'b1, 1'b0, 1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    step("re_nop", 1'b0, 1'b1, 1'b0, 7'h00, 5'd31, 5'd17, 5'd9, 16'h1234);
    check_eq("nop.word", 64'(imem_wdata), 64'd0);

    // Overflow: five back-to-back legal words without LAST
    step("ovf_start", 1'b1, 1'b0, 1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    for (int i = 0; i < 5; i++)
      step("ovf", 1'b0, 1'b1, 1'b0, 7'h05, 5'(i), 5'd2, 5'd3, 16'h0);
    check_eq("ovf.code", 64'(err_code), 64'(2'b11));
    check_eq("ovf.count", 64'(word_count), 64'd4);

    // Randomized sessions
    for (int sess = 0; sess < 60; sess++) begin
      step("rnd_start", 1'b1, 1'($urandom_range(0, 1)), 1'b0, pick_legal(),
           5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
      for (int c = 0; c < 7; c++) begin
        op_r = ($urandom_range(0, 19) == 0) ? 7'($urandom) : pick_legal();
        sel = $urandom_range(0, 3);
        case (sel)
          0: imm_r = 16'($urandom);
          1: imm_r = 16'($urandom_range(0, 255));
          2: begin
            case ($urandom_range(0, 6))
              0: imm_r = 16'd16383;
              1: imm_r = 16'd16384;
              2: imm_r = 16'hC000;
              3: imm_r = 16'hBFFF;
              4: imm_r = 16'h7FFF;
              5: imm_r = 16'hFFFF;
              default: imm_r = 16'h0000;
            endcase
          end
          default: imm_r = {1'b0, 15'($urandom)};
        endcase
        step("rnd", 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 5) == 0), op_r, 5'($urandom), 5'($urandom),
             5'($urandom), imm_r);
      end
    end

    // Reset mid-stream clears outputs asynchronously
    step("rst_start", 1'b1, 1'b0, 1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    step("rst_w", 1'b0, 1'b1, 1'b0, 7'h09, 5'd4, 5'd5, 5'd6, 16'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    m_state = 0; m_addr = 0; m_count = 0; m_code = 0; m_cks = 32'h0;
    @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b1, 1'b0, 7'h02, 5'd1, 5'd1, 5'd1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
